// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
//   Groups the byte-ingest, pop and status signals of uart_rx_fifo.
//   The master modport belongs to whoever drives the receiver flag and the
//   consumer pops. The slave modport belongs to the FIFO itself.
//
//   rx_data   received byte, valid while rx_ready=1       (master -> slave)
//   rx_ready  receiver done flag, level-held              (master -> slave)
//   rd_en     pop request                                 (master -> slave)
//   clr_ovf   synchronous clear of the sticky overflow    (master -> slave)
//   rd_data   head-of-FIFO byte, first-word-fall-through  (slave -> master)
//   empty     FIFO holds no bytes                         (slave -> master)
//   full      FIFO holds DEPTH bytes                      (slave -> master)
//   count     bytes held, 0..DEPTH                        (slave -> master)
//   overflow  sticky flag, at least one byte was dropped  (slave -> master)
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;
  logic              rd_en;
  logic              clr_ovf;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output rx_data, rx_ready, rd_en, clr_ovf,
    input  rd_data, empty, full, count, overflow
  );

  modport slave (
    input  rx_data, rx_ready, rd_en, clr_ovf,
    output rd_data, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer that sits directly after the UART receiver.
//   The receiver's level-held rx_ready flag is edge-detected, so each byte is
//   written exactly once. Bytes go into a circular FIFO. The consumer sees
//   them on a first-word-fall-through read port. A byte that arrives while
//   the FIFO is full, with no pop in that cycle, is dropped and sets a
//   sticky overflow flag. Stored data is never overwritten.
//
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   uart_rx_fifo_if.slave; see the interface file for each signal
//
//   Parameters: DATA_W (byte width), DEPTH (entries; a power of 2, >= 2).
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic              rdy_q,      rdy_d;
  logic [ADDR_W-1:0] wptr_q,     wptr_d;
  logic [ADDR_W-1:0] rptr_q,     rptr_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic              overflow_q, overflow_d;

  logic [DATA_W-1:0] mem [DEPTH];

  // -------------------------------------------------------------------------
  // Event decode
  // -------------------------------------------------------------------------
  logic empty_w;
  logic full_w;
  logic wr;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    empty_w = (count_q == '0);
    full_w  = (count_q == FULL_CNT);

    // One strobe per rising edge of rx_ready. The strobe is also gated by
    // rst, so a byte cannot be written while the design is held in reset.
    wr   = bus.rx_ready & ~rdy_q & ~rst;
    pop  = bus.rd_en & ~empty_w;
    // When the FIFO is full, a pop in the same cycle frees the slot that
    // the new byte takes.
    push = wr & (~full_w | pop);
    drop = wr & full_w & ~pop;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal gets its default value first, so no path through this
  // block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    rdy_d      = bus.rx_ready;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // Pointers wrap on their own because DEPTH is a power of 2.
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A new drop wins over a clear in the same cycle, so no lost byte goes
    // unreported.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) assignments.
  // This way every flop samples the values from before the edge, whatever
  // order the statements are written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rdy_q      <= rdy_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset on purpose. Reset empties the FIFO
  // by clearing the pointers and the count. Stale entries are never visible,
  // because rd_data is forced to 0 while the FIFO is empty. Leaving the array
  // out of reset also lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= bus.rx_data;
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.rd_data  = empty_w ? '0 : mem[rptr_q];
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed, self-checking bench for uart_rx_fifo with DATA_W=8, DEPTH=16.
//   Inputs are driven 1 time unit after each rising edge, and outputs are
//   sampled at that same point.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  uart_rx_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise rx_ready for one edge, then drop it for one edge so that the next
  // byte produces a fresh rising edge.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    tick();
  endtask

  task automatic pop_only();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    logic [7:0] b;
    b = base;
    for (int i = 0; i < n; i++) begin
      send_byte(b);
      b = b + 8'd1;
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    bus.rx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    bus.rd_en    = 1'b0;
    bus.clr_ovf  = 1'b0;
    rst          = 1'b1;
    #12;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", bus.rd_data); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_long_level();
    bus.rx_data  = 8'h55;
    bus.rx_ready = 1'b1;
    tick();
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL long_first_count: got %0d expected 1", bus.count); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL long_first_empty: got %b expected 0", bus.empty); end
    checks++; if (bus.rd_data !== 8'h55) begin errors++; $display("FAIL long_first_data: got %h expected 55", bus.rd_data); end
    repeat (2000) tick();
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL long_hold_count: got %0d expected 1", bus.count); end
    bus.rx_ready = 1'b0;
    tick();
    pop_only();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL long_pop_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL long_pop_data: got %h expected 00", bus.rd_data); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_fill_overflow();
    logic [7:0] exp_b;
    fill(8'h01, 16);
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", bus.full); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d expected 16", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_clear: got %b expected 0", bus.overflow); end
    send_byte(8'hEE);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.overflow); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", bus.count); end
    exp_b = 8'h01;
    for (int i = 0; i < 16; i++) begin
      checks++; if (bus.rd_data !== exp_b) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, bus.rd_data, exp_b); end
      pop_only();
      exp_b = exp_b + 8'd1;
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL drain_rd_zero: got %h expected 00", bus.rd_data); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_full_simul();
    logic [7:0] exp_b;
    fill(8'h20, 16);
    bus.rx_data  = 8'h99;
    bus.rx_ready = 1'b1;
    bus.rd_en    = 1'b1;
    tick();
    bus.rd_en    = 1'b0;
    bus.rx_ready = 1'b0;
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL fullsim_count: got %0d expected 16", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fullsim_ovf: got %b expected 0", bus.overflow); end
    checks++; if (bus.rd_data !== 8'h21) begin errors++; $display("FAIL fullsim_head: got %h expected 21", bus.rd_data); end
    tick();
    exp_b = 8'h21;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_b = 8'h99;
      checks++; if (bus.rd_data !== exp_b) begin errors++; $display("FAIL fullsim_drain[%0d]: got %h expected %h", i, bus.rd_data, exp_b); end
      pop_only();
      exp_b = exp_b + 8'd1;
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fullsim_empty: got %b expected 1", bus.empty); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_empty_simul();
    bus.rx_data  = 8'hA3;
    bus.rx_ready = 1'b1;
    bus.rd_en    = 1'b1;
    tick();
    bus.rd_en    = 1'b0;
    bus.rx_ready = 1'b0;
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL emptysim_count: got %0d expected 1", bus.count); end
    checks++; if (bus.rd_data !== 8'hA3) begin errors++; $display("FAIL emptysim_data: got %h expected a3", bus.rd_data); end
    tick();
    pop_only();
    repeat (3) pop_only();
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL empty_read_count: got %0d expected 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL empty_read_empty: got %b expected 1", bus.empty); end
    send_byte(8'h5A);
    checks++; if (bus.rd_data !== 8'h5A) begin errors++; $display("FAIL empty_read_ptr: got %h expected 5a", bus.rd_data); end
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL empty_read_recount: got %0d expected 1", bus.count); end
    pop_only();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] b;
    bit         up;
    int         n_pop;
    up = 1'b1;
    b  = 8'h80;
    for (int i = 0; i < 40; i++) begin
      send_byte(b);
      q.push_back(b);
      b = b + 8'd1;
      checks++; if (bus.count !== q.size()) begin errors++; $display("FAIL wrap_push_count[%0d]: got %0d expected %0d", i, bus.count, q.size()); end
      if (q.size() >= 14) up = 1'b0;
      if (q.size() <= 3)  up = 1'b1;
      if (!up)                          n_pop = 2;
      else if (q.size() >= 4 && i % 3 == 0) n_pop = 1;
      else                              n_pop = 0;
      for (int k = 0; k < n_pop; k++) begin
        checks++; if (bus.rd_data !== q[0]) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, bus.rd_data, q[0]); end
        pop_only();
        void'(q.pop_front());
        checks++; if (bus.count !== q.size()) begin errors++; $display("FAIL wrap_pop_count[%0d]: got %0d expected %0d", i, bus.count, q.size()); end
      end
    end
    while (q.size() > 0) begin
      checks++; if (bus.rd_data !== q[0]) begin errors++; $display("FAIL wrap_tail_data: got %h expected %h", bus.rd_data, q[0]); end
      pop_only();
      void'(q.pop_front());
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", bus.empty); end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid();
    fill(8'h60, 16);
    send_byte(8'hEE);
    repeat (11) pop_only();
    checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL mid_pre_count: got %0d expected 5", bus.count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL mid_pre_ovf: got %b expected 1", bus.overflow); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b expected 1", bus.empty); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", bus.overflow); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL mid_rd_data: got %h expected 00", bus.rd_data); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    fill(8'h70, 16);
    bus.rx_data  = 8'hC7;
    bus.rx_ready = 1'b1;
    bus.clr_ovf  = 1'b1;
    tick();
    bus.clr_ovf  = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL clr_vs_set: got %b expected 1", bus.overflow); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL clr_vs_set_count: got %0d expected 16", bus.count); end
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf  = 1'b0;
    bus.rx_ready = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b expected 0", bus.overflow); end
    checks++; if (bus.rd_data !== 8'h70) begin errors++; $display("FAIL clr_head: got %h expected 70", bus.rd_data); end
    tick();
  endtask

  // -------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_long_level();
    test_fill_overflow();
    test_full_simul();
    test_empty_simul();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
